stopwatch_counter: RTL

Consumes the one-second (or ten-second) tick from the upstream tick timer and keeps the stopwatch time as BCD MM:SS (00:00–59:59). Owns the start/stop/clear control FSM and drives the timer's enable and ten-second select. Provides a lap-hold capture and the display digits for the seven-segment stage downstream.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_counter_if.sv | 31 +++
 rtl/bcd_time_inc.sv | 60 ++++++
 rtl/stopwatch_counter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter: FSM states and the BCD MM:SS time word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [2:0] BCD_MAX_TENS = 3'd5;
  localparam bcd_time_t  TIME_ZERO    = '0;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control, timer and display signals of the stopwatch counter, grouped for the top-level port.
interface stopwatch_counter_if;

  logic       second_tick;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       ten_sec_mode;
  logic       timer_enable;
  logic       ten_sec_enable;
  logic       running;
  logic       lap_hold;
  logic       rollover;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output second_tick, start_stop, clear, lap, ten_sec_mode,
    input  timer_enable, ten_sec_enable, running, lap_hold, rollover,
    input  min_tens, min_ones, sec_tens, sec_ones
  );

  modport slave (
    input  second_tick, start_stop, clear, lap, ten_sec_mode,
    output timer_enable, ten_sec_enable, running, lap_hold, rollover,
    output min_tens, min_ones, sec_tens, sec_ones
  );

endinterface

// File: rtl/bcd_time_inc.sv
// Combinational BCD MM:SS incrementer: +1 s, or +10 s when ten_step is set, with overflow past 59:59.
module bcd_time_inc
  import stopwatch_pkg::*;
(
  input  bcd_time_t cur,
  input  logic      ten_step,
  output bcd_time_t nxt,
  output logic      overflow
);

  logic carry_sec_tens;
  logic carry_min_ones;
  logic carry_min_tens;

  always_comb begin
    nxt            = cur;
    overflow       = 1'b0;
    carry_sec_tens = ten_step;
    carry_min_ones = 1'b0;
    carry_min_tens = 1'b0;

    // Ten-second steps bypass the seconds-ones digit entirely.
    if (!ten_step) begin
      if (cur.sec_ones == BCD_MAX_ONES) begin
        nxt.sec_ones   = '0;
        carry_sec_tens = 1'b1;
      end else begin
        nxt.sec_ones = cur.sec_ones + 4'd1;
      end
    end

    if (carry_sec_tens) begin
      if (cur.sec_tens == BCD_MAX_TENS) begin
        nxt.sec_tens   = '0;
        carry_min_ones = 1'b1;
      end else begin
        nxt.sec_tens = cur.sec_tens + 3'd1;
      end
    end

    if (carry_min_ones) begin
      if (cur.min_ones == BCD_MAX_ONES) begin
        nxt.min_ones   = '0;
        carry_min_tens = 1'b1;
      end else begin
        nxt.min_ones = cur.min_ones + 4'd1;
      end
    end

    if (carry_min_tens) begin
      if (cur.min_tens == BCD_MAX_TENS) begin
        nxt.min_tens = '0;
        overflow     = 1'b1;
      end else begin
        nxt.min_tens = cur.min_tens + 3'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time keeper: start/stop/clear FSM, tick edge acceptance, BCD count, lap hold and display mux.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter bit WRAP_AT_MAX = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  stopwatch_counter_if.slave  bus
);

  sw_state_t state_q, state_d;
  bcd_time_t live_q, live_d;
  bcd_time_t lap_q, lap_d;
  bcd_time_t live_inc;
  bcd_time_t disp;
  logic      tick_prev_q;
  logic      lap_hold_q, lap_hold_d;
  logic      rollover_q, rollover_d;
  logic      ten_sec_q, ten_sec_d;
  logic      accepted;
  logic      overflow;
  logic      do_clear;

  bcd_time_inc u_inc (
    .cur      (live_q),
    .ten_step (ten_sec_q),
    .nxt      (live_inc),
    .overflow (overflow)
  );

  // A held-high tick must not count again after a pause, so only rising edges are accepted.
  assign accepted = bus.second_tick & ~tick_prev_q & (state_q == RUNNING);
  assign do_clear = bus.clear & (state_q == PAUSED);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_stop) state_d = RUNNING;
      end
      RUNNING: begin
        if (bus.start_stop || (accepted && overflow && !WRAP_AT_MAX)) state_d = PAUSED;
      end
      PAUSED: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else if (bus.start_stop) begin
          state_d = RUNNING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    live_d     = live_q;
    lap_d      = lap_q;
    lap_hold_d = lap_hold_q;
    rollover_d = accepted & overflow;
    ten_sec_d  = (state_q == IDLE) ? bus.ten_sec_mode : ten_sec_q;

    if (do_clear) begin
      live_d     = TIME_ZERO;
      lap_d      = TIME_ZERO;
      lap_hold_d = 1'b0;
    end else begin
      if (bus.lap && lap_hold_q && (state_q != IDLE)) begin
        lap_hold_d = 1'b0;
      end else if (bus.lap && !lap_hold_q && (state_q == RUNNING)) begin
        lap_d      = live_q;
        lap_hold_d = 1'b1;
      end
      if (accepted) begin
        if (!overflow) begin
          live_d = live_inc;
        end else if (WRAP_AT_MAX) begin
          live_d = TIME_ZERO;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      live_q      <= TIME_ZERO;
      lap_q       <= TIME_ZERO;
      tick_prev_q <= 1'b0;
      lap_hold_q  <= 1'b0;
      rollover_q  <= 1'b0;
      ten_sec_q   <= 1'b0;
    end else begin
      live_q      <= live_d;
      lap_q       <= lap_d;
      tick_prev_q <= bus.second_tick;
      lap_hold_q  <= lap_hold_d;
      rollover_q  <= rollover_d;
      ten_sec_q   <= ten_sec_d;
    end
  end

  always_comb begin
    disp               = lap_hold_q ? lap_q : live_q;
    bus.timer_enable   = (state_q == RUNNING);
    bus.running        = (state_q == RUNNING);
    bus.ten_sec_enable = ten_sec_q;
    bus.lap_hold       = lap_hold_q;
    bus.rollover       = rollover_q;
    bus.min_tens       = disp.min_tens;
    bus.min_ones       = disp.min_ones;
    bus.sec_tens       = disp.sec_tens;
    bus.sec_ones       = disp.sec_ones;
  end

endmodule
